// File: rtl/spi_spram_bridge.sv
// spi_spram_bridge
// SPI mode-0 slave (MSB first) giving a host byte-addressed read/write burst
// access to one 16-bit synchronous single-port memory. Addresses auto-increment.
// All SPI pins are oversampled in the clk domain; SCLK must be at most clk/8.
//
// Frame: <opcode> <addr[15:8]> <addr[7:0]> <data...>
//   CMD_WRITE: each received data byte is written to the addressed byte lane.
//   CMD_READ : each addressed byte is returned on MISO, prefetched one byte ahead.
//
// Ports
//   clk, rst_n         system clock, async active-low reset
//   SPI_SCLK/MOSI/CE0  SPI inputs (async), CE0 active low
//   SPI_MISO           SPI data out, 0 outside a read data phase
//   mem_*              generic sync memory port, 1-cycle read latency
//   active             frame in progress
//   cmd_err            1-cycle pulse on an unrecognised opcode
`timescale 1ns/1ps
module spi_spram_bridge #(
  parameter int          ADDR_W      = 14,
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  CMD_READ    = 8'h03,
  parameter logic [7:0]  CMD_WRITE   = 8'h02
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SPI_SCLK,
  input  logic              SPI_MOSI,
  input  logic              SPI_CE0,
  output logic              SPI_MISO,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [3:0]        mem_maskwren,
  output logic              mem_wren,
  output logic              mem_cs,
  input  logic [15:0]       mem_rdata,
  output logic              active,
  output logic              cmd_err
);

  localparam int BA_W = ADDR_W + 1;  // byte address width

  typedef enum logic [2:0] {
    S_WAIT_CS_HIGH, S_IDLE, S_CMD, S_ADDR, S_RD, S_WR, S_IGNORE
  } state_e;

  // Same synchroniser depth on all three pins keeps MOSI aligned to SCLK.
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ce_sync_q;
  logic sclk_prev_q, ce_prev_q;
  logic sclk_s, mosi_s, ce_s;
  logic sclk_rise, sclk_fall, ce_rise, ce_fall;

  state_e            state_q, state_d;
  logic [BA_W-1:0]   rx_sr_q, rx_sr_d, rx_nxt;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [BA_W-1:0]   addr_q, addr_d;
  logic [7:0]        tx_sr_q, tx_sr_d;
  logic              is_rd_q, is_rd_d;
  logic              rd_lane_q, rd_lane_d;
  logic              rd_pend_q, rd_load_q;
  logic              mem_cs_q, mem_cs_d, mem_wren_q, mem_wren_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_mask_q, mem_mask_d;
  logic              cmd_err_q, cmd_err_d;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ce_s      = ce_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s &  sclk_prev_q;
  assign ce_rise   =  ce_s   & ~ce_prev_q;
  assign ce_fall   = ~ce_s   &  ce_prev_q;
  assign rx_nxt    = {rx_sr_q[BA_W-2:0], mosi_s};

  // The MSB of the shift register is always shifted out, never read.
  logic unused_sr_msb;
  assign unused_sr_msb = rx_sr_q[BA_W-1];

  always_comb begin
    state_d     = state_q;
    rx_sr_d     = rx_sr_q;
    bit_cnt_d   = bit_cnt_q;
    addr_d      = addr_q;
    tx_sr_d     = tx_sr_q;
    is_rd_d     = is_rd_q;
    rd_lane_d   = rd_lane_q;
    mem_cs_d    = 1'b0;
    mem_wren_d  = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_mask_d  = mem_mask_q;
    cmd_err_d   = 1'b0;

    // Read data arrives the cycle after mem_cs; it lands in tx_sr well before
    // the next falling edge. The falling edge right after a byte boundary
    // (bit_cnt==0) must not shift, or the freshly loaded MSB would be lost.
    if (rd_load_q)
      tx_sr_d = rd_lane_q ? mem_rdata[7:0] : mem_rdata[15:8];
    else if (state_q == S_RD && sclk_fall && bit_cnt_q != 5'd0)
      tx_sr_d = {tx_sr_q[6:0], 1'b0};

    unique case (state_q)
      S_WAIT_CS_HIGH: if (ce_s) state_d = S_IDLE;
      S_IDLE: if (ce_fall) begin
        state_d   = S_CMD;
        bit_cnt_d = 5'd0;
      end
      S_CMD: if (sclk_rise) begin
        rx_sr_d   = rx_nxt;
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd7) begin
          bit_cnt_d = 5'd0;
          if (rx_nxt[7:0] == CMD_READ || rx_nxt[7:0] == CMD_WRITE) begin
            state_d = S_ADDR;
            is_rd_d = (rx_nxt[7:0] == CMD_READ);
          end else begin
            state_d   = S_IGNORE;
            cmd_err_d = 1'b1;
          end
        end
      end
      S_ADDR: if (sclk_rise) begin
        rx_sr_d   = rx_nxt;
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd15) begin
          bit_cnt_d = 5'd0;
          if (is_rd_q) begin
            state_d    = S_RD;
            mem_cs_d   = 1'b1;
            mem_addr_d = rx_nxt[BA_W-1:1];
            rd_lane_d  = rx_nxt[0];
            addr_d     = rx_nxt + 1'b1;
          end else begin
            state_d = S_WR;
            addr_d  = rx_nxt;
          end
        end
      end
      S_RD: if (sclk_rise) begin
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q[2:0] == 3'd7) begin  // prefetch the next byte
          bit_cnt_d  = 5'd0;
          mem_cs_d   = 1'b1;
          mem_addr_d = addr_q[BA_W-1:1];
          rd_lane_d  = addr_q[0];
          addr_d     = addr_q + 1'b1;
        end
      end
      S_WR: if (sclk_rise) begin
        rx_sr_d   = rx_nxt;
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q[2:0] == 3'd7) begin
          bit_cnt_d   = 5'd0;
          mem_cs_d    = 1'b1;
          mem_wren_d  = 1'b1;
          mem_addr_d  = addr_q[BA_W-1:1];
          mem_wdata_d = {rx_nxt[7:0], rx_nxt[7:0]};
          mem_mask_d  = addr_q[0] ? 4'b0011 : 4'b1100;
          addr_d      = addr_q + 1'b1;
        end
      end
      S_IGNORE: ;
      default: state_d = S_WAIT_CS_HIGH;
    endcase

    // CE0 rising ends the frame and beats a coincident byte-completing edge.
    if (state_q != S_WAIT_CS_HIGH && ce_rise) begin
      state_d    = S_IDLE;
      bit_cnt_d  = 5'd0;
      mem_cs_d   = 1'b0;
      mem_wren_d = 1'b0;
      cmd_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ce_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      ce_prev_q   <= 1'b0;
      state_q     <= S_WAIT_CS_HIGH;
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      addr_q      <= '0;
      tx_sr_q     <= '0;
      is_rd_q     <= 1'b0;
      rd_lane_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
      rd_load_q   <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_mask_q  <= '0;
      cmd_err_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], SPI_CE0};
      sclk_prev_q <= sclk_s;
      ce_prev_q   <= ce_s;
      state_q     <= state_d;
      rx_sr_q     <= rx_sr_d;
      bit_cnt_q   <= bit_cnt_d;
      addr_q      <= addr_d;
      tx_sr_q     <= tx_sr_d;
      is_rd_q     <= is_rd_d;
      rd_lane_q   <= rd_lane_d;
      rd_pend_q   <= mem_cs_d & ~mem_wren_d;
      rd_load_q   <= rd_pend_q;
      mem_cs_q    <= mem_cs_d;
      mem_wren_q  <= mem_wren_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_mask_q  <= mem_mask_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign mem_cs       = mem_cs_q;
  assign mem_wren     = mem_wren_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_maskwren = mem_mask_q;
  assign cmd_err      = cmd_err_q;
  assign active       = (state_q != S_WAIT_CS_HIGH) && (state_q != S_IDLE);
  assign SPI_MISO     = (state_q == S_RD) && !ce_s && tx_sr_q[7];

endmodule

// File: doc/spi_spram_bridge.md
Name: spi_spram_bridge

Overview:
SPI mode-0 slave (MSB first) that gives the host byte-addressed read and write burst access to one SPRAM-style 16-bit memory, with auto-incrementing addresses. It replaces the fixed 8-bit-address, read-only SPI reader. All SPI inputs are oversampled in the single system clock domain. The block drives a generic synchronous memory port, so it can sit in front of an SB_SPRAM256KA or a behavioural model.

Parameters:
ADDR_W, 14, memory word-address width; byte address width is ADDR_W+1 (max 16).
SYNC_STAGES, 2, synchroniser depth on SPI_SCLK, SPI_MOSI and SPI_CE0 (min 2).
CMD_READ, 8'h03, read command opcode.
CMD_WRITE, 8'h02, write command opcode.

Ports:
clk  in  1  system clock (48 MHz HFOSC).
rst_n  in  1  asynchronous active-low reset.
SPI_SCLK  in  1  SPI clock, async to clk.
SPI_MOSI  in  1  SPI data in.
SPI_CE0  in  1  chip select, active low.
SPI_MISO  out  1  SPI data out.
mem_addr  out  ADDR_W  word address.
mem_wdata  out  16  write data; the byte is replicated on both lanes.
mem_maskwren  out  4  nibble write mask.
mem_wren  out  1  write strobe.
mem_cs  out  1  access strobe; 1-cycle read latency.
mem_rdata  in  16  read data, valid the cycle after mem_cs with mem_wren=0.
active  out  1  frame in progress.
cmd_err  out  1  1-cycle pulse on an unrecognised command byte.

Behaviour:
- Reset: all outputs 0; FSM=WAIT_CS_HIGH; shift registers, bit counter and address cleared.
- Input sync: SYNC_STAGES flops per input. Edges are detected on synchronised SCLK. Rising edge samples MOSI; falling edge shifts MISO. Supported SCLK is at most clk/8.
- FSM:
  - WAIT_CS_HIGH -> IDLE once CE0 is high. This prevents a frame from starting mid-transfer after reset.
  - IDLE -> CMD on CE0 falling.
  - CMD: collects 8 bits. On the 8th rising edge:
    - opcode = CMD_READ or CMD_WRITE -> ADDR.
    - otherwise pulse cmd_err and go to IGNORE.
  - ADDR: collects 16 bits MSB first. Byte address = low ADDR_W+1 bits; upper bits are ignored. Then go to RD or WR.
  - RD: on the cycle after the last address bit, or after the 8th bit of each data byte, issue a read: mem_cs=1, mem_wren=0, mem_addr=addr[ADDR_W:1].
    - The next cycle loads tx_sr with mem_rdata[15:8] if addr[0]=0, else mem_rdata[7:0].
    - Address then increments.
    - The load must complete before the next SCLK falling edge.
  - WR: on each 8th data bit rising edge, issue one write cycle, then increment the address.
    - mem_cs=1, mem_wren=1, mem_wdata={b,b}.
    - mem_maskwren=4'b1100 if addr[0]=0, else 4'b0011.
  - IGNORE: no memory access; MISO=0.
  - Any state except WAIT_CS_HIGH -> IDLE on CE0 rising.
- MISO: tx_sr[7] in RD; shifted left on falling edges; 0 in all other states and whenever CE0 is high.
- Address arithmetic: modulo 2^(ADDR_W+1). 0x7FFF+1 wraps to 0x0000 for ADDR_W=14.
- Partial byte at CE0 rise: discarded; no write is issued. A write pulse already issued is never cancelled.
- active: 1 from CE0 falling until CE0 rising.
- Simultaneous CE0 rise and 8th bit edge: CE0 wins; the byte is discarded.
- mem_cs and mem_wren are single-cycle pulses, never asserted back to back.
- rst_n asserted mid-frame: strobes clear immediately; FSM returns to WAIT_CS_HIGH.

Test Plan:
- Write then read:
  - Frame 02 00 10 A5 3C -> writes word 0x0008 with mask 1100 (data A5A5), then mask 0011 (data 3C3C).
  - Frame 03 00 10 xx xx -> MISO returns A5, 3C.
- Odd start and wrap: write 02 7F FF 11 22 -> word 0x3FFF low lane = 11, word 0x0000 high lane = 22. Read back 03 7F FF returns 11 22.
- Bad command: opcode 0x9F -> one cmd_err pulse; zero mem_cs for rest of frame; MISO held 0.
- Partial byte: 02 00 00 then 5 bits, CE0 high -> zero mem_wren pulses; active falls within SYNC_STAGES+1 clk.
- Reset with CE0 low: release rst_n while CE0=0, clock 24 bits -> no access and no cmd_err. Raise then drop CE0; read frame works normally.
- Timing stress: SCLK=clk/8 with random SCLK phase, 64-byte write/read burst at 0x1234 -> read data matches the written pattern byte for byte.
